mips_register_file: RTL and testbench
=====================================

// Module: mips_register_file
// PURPOSE
//   32 x 32-bit general-purpose register file for the 32-bit MIPS datapath.
//   Sits directly upstream of the 32-bit ALU (array of 1-bit ALU slices) and supplies its a/b operands.
//   Two registered read ports and one synchronous write port.
//   Register $0 reads as zero; write-to-read bypass hides the WB->ID hazard.
// PARAMETERS
//   DATA_WIDTH   32  width of each register and of the data ports
//   ADDR_WIDTH   5   register address width; depth = 2**ADDR_WIDTH = 32
//   BYPASS_EN    1   1: same-cycle write data forwarded to read ports; 0: old contents returned
// PORTS
//   clk          in   1           single clock, rising edge
//   rst_n        in   1           asynchronous, active-low reset
//   read_en      in   1           capture new read results this cycle (0 = hold outputs)
//   read_reg1    in   ADDR_WIDTH  rs address -> read_data1
//   read_reg2    in   ADDR_WIDTH  rt address -> read_data2
//   reg_write    in   1           write strobe
//   write_reg    in   ADDR_WIDTH  destination address
//   write_data   in   DATA_WIDTH  write value
//   read_data1   out  DATA_WIDTH  operand A to ALU, registered
//   read_data2   out  DATA_WIDTH  operand B to ALU, registered
//   read_valid   out  1           high the cycle after a read_en cycle
// BEHAVIOUR
//   Clock/reset: one clock; reset is asynchronous and active-low.
//   Reset (rst_n=0, any time, including mid-operation):
//     - all 32 registers, read_data1/2 and read_valid -> 0 immediately, no clock needed.
//     - First write is accepted on the first rising edge with rst_n=1.
//   Write:
//     - On a rising edge with reg_write=1 and write_reg!=0: mem[write_reg] <= write_data.
//     - A write to $0 is discarded; mem[0] is never stored and is constant 0.
//   Read (latency 1):
//     - On a rising edge with read_en=1: read_dataN <= value(read_regN); read_valid <= 1.
//     - Any edge with read_en=0: read_data1/2 hold; read_valid <= 0.
//   value(addr):
//     - addr==0                                          -> 0 (even if a write targets 0 that cycle)
//     - BYPASS_EN && reg_write && write_reg==addr        -> write_data (bypass)
//     - otherwise                                        -> mem[addr] before this edge
//   Simultaneous events:
//     - Both ports may read the same address; both receive the same value.
//     - Write and read of the same register in one cycle follow the bypass rule above.
//   Arithmetic: none; pure storage, no sign/zero extension; the ALU consumes full width.
//   Unknowns: X on read_reg* while read_en=0 must not change outputs.
// STRUCTURE
//   Package mips_pkg (shared):
//     - REG_ZERO=5'd0, REG_COUNT=32, DATA_WIDTH=32, ADDR_WIDTH=5.
//     - Named register indices used by decode and bench, e.g. REG_SP=29, REG_RA=31.
//   Sub-module: mips_reg_cell.
//     - One DATA_WIDTH flop with enable and async active-low clear; instantiated 31 times (1..31).
//   Top level: write-address decode to cell enables, two 32:1 read muxes, bypass compare, output flops.
// TESTING
//   1. rst_n=0 mid-run after loading r5=32'hDEADBEEF
//      -> read_data1/2=0 and read_valid=0 at once; a later read of r5 returns 0.
//   2. Write r8=32'h0000_00FF; next cycle read_reg1=8, read_en=1
//      -> read_data1=32'h0000_00FF one edge later, read_valid=1.
//   3. Write $0=32'hFFFF_FFFF and read_reg1=0 in the same cycle
//      -> read_data1=0; a later read of $0 also returns 0.
//   4. BYPASS_EN=1: same cycle write r3=32'h1234_5678, read_reg1=read_reg2=3
//      -> both outputs 32'h1234_5678.
//      Rerun with BYPASS_EN=0 -> both return the prior r3 value.
//   5. read_en=0 while read_reg1 toggles 1->2->X
//      -> read_data1 holds its last captured value; read_valid=0.
//   6. Write r31=32'h8000_0000 and r1=32'h7FFF_FFFF, then read both
//      -> drive the 32-bit ALU with AluOp=110 (sub), read_data1=r1, read_data2=r31
//      -> ALU result 32'hFFFF_FFFF.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register file geometry and named register indices.
package mips_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int REG_COUNT  = 32;

    localparam logic [ADDR_WIDTH-1:0] REG_ZERO = 5'd0;
    localparam logic [ADDR_WIDTH-1:0] REG_AT   = 5'd1;
    localparam logic [ADDR_WIDTH-1:0] REG_V0   = 5'd2;
    localparam logic [ADDR_WIDTH-1:0] REG_T0   = 5'd8;
    localparam logic [ADDR_WIDTH-1:0] REG_SP   = 5'd29;
    localparam logic [ADDR_WIDTH-1:0] REG_FP   = 5'd30;
    localparam logic [ADDR_WIDTH-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/mips_reg_cell.sv
// One general-purpose register: a DATA_WIDTH flop with load enable and async active-low clear.
module mips_reg_cell #(
    parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] data_d;
    logic [DATA_WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/mips_register_file.sv
// 32 x 32 MIPS register file: two registered read ports, one write port, $0 hardwired to zero,
// optional write-to-read bypass so a WB write is visible to the ID read in the same cycle.
module mips_register_file #(
    parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mips_pkg::ADDR_WIDTH,
    parameter bit BYPASS_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    output logic                  read_valid
);

    import mips_pkg::*;

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] cell_q [DEPTH];
    logic                  wr_ok;

    assign wr_ok     = reg_write && (write_reg != ZERO_ADDR);
    assign cell_q[0] = '0;

    // $0 has no storage; cells exist only for registers 1..DEPTH-1.
    for (genvar g = 1; g < DEPTH; g++) begin : g_cell
        mips_reg_cell #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (wr_ok && (write_reg == ADDR_WIDTH'(g))),
            .d     (write_data),
            .q     (cell_q[g])
        );
    end

    logic [DATA_WIDTH-1:0] val1;
    logic [DATA_WIDTH-1:0] val2;
    logic [DATA_WIDTH-1:0] rd1_d, rd1_q;
    logic [DATA_WIDTH-1:0] rd2_d, rd2_q;
    logic                  valid_d, valid_q;

    // Zero-register check is applied last so it overrides a bypass hit on $0.
    always_comb begin
        val1 = cell_q[read_reg1];
        if (BYPASS_EN && wr_ok && (write_reg == read_reg1)) begin
            val1 = write_data;
        end
        if (read_reg1 == ZERO_ADDR) begin
            val1 = '0;
        end

        val2 = cell_q[read_reg2];
        if (BYPASS_EN && wr_ok && (write_reg == read_reg2)) begin
            val2 = write_data;
        end
        if (read_reg2 == ZERO_ADDR) begin
            val2 = '0;
        end
    end

    always_comb begin
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        valid_d = read_en;
        if (read_en) begin
            rd1_d = val1;
            rd2_d = val2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_q   <= '0;
            rd2_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            valid_q <= valid_d;
        end
    end

    assign read_data1 = rd1_q;
    assign read_data2 = rd2_q;
    assign read_valid = valid_q;

endmodule

// File: tb/tb_mips_register_file.sv
// Scoreboard bench for mips_register_file: bypass and non-bypass instances share one stimulus stream.
module tb_mips_register_file;

    logic        clk;
    logic        rst_n;
    logic        read_en;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        vb, vn;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] d1b;
        logic [31:0] d2b;
        logic [31:0] d1n;
        logic [31:0] d2n;
        logic        v;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_m [32];
    logic [31:0] hb1, hb2, hn1, hn2;

    mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS_EN(1'b1)) u_byp (
        .clk(clk), .rst_n(rst_n), .read_en(read_en), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .read_data1(rd1_b), .read_data2(rd2_b), .read_valid(vb)
    );

    mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS_EN(1'b0)) u_nob (
        .clk(clk), .rst_n(rst_n), .read_en(read_en), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .read_data1(rd1_n), .read_data2(rd2_n), .read_valid(vn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mval(input logic [4:0] addr, input bit byp,
                                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        if (addr == 5'd0) return 32'h0;
        if (byp && we && (wa == addr)) return wd;
        return mem_m[addr];
    endfunction

    // Output monitor: pops one expectation per rising edge driven by cyc.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks += 6;
            if (rd1_b !== e.d1b) begin n_errors++; $display("FAIL byp_rd1 got %h exp %h", rd1_b, e.d1b); end
            if (rd2_b !== e.d2b) begin n_errors++; $display("FAIL byp_rd2 got %h exp %h", rd2_b, e.d2b); end
            if (rd1_n !== e.d1n) begin n_errors++; $display("FAIL nob_rd1 got %h exp %h", rd1_n, e.d1n); end
            if (rd2_n !== e.d2n) begin n_errors++; $display("FAIL nob_rd2 got %h exp %h", rd2_n, e.d2n); end
            if (vb !== e.v) begin n_errors++; $display("FAIL byp_valid got %b exp %b", vb, e.v); end
            if (vn !== e.v) begin n_errors++; $display("FAIL nob_valid got %b exp %b", vn, e.v); end
        end
    end

    task automatic cyc(input logic re, input logic [4:0] a1, input logic [4:0] a2,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
        exp_t e;
        @(negedge clk);
        read_en    = re;
        read_reg1  = a1;
        read_reg2  = a2;
        reg_write  = we;
        write_reg  = wa;
        write_data = wd;
        if (re) begin
            hb1 = mval(a1, 1'b1, we, wa, wd);
            hb2 = mval(a2, 1'b1, we, wa, wd);
            hn1 = mval(a1, 1'b0, we, wa, wd);
            hn2 = mval(a2, 1'b0, we, wa, wd);
        end
        e.d1b = hb1; e.d2b = hb2; e.d1n = hn1; e.d2n = hn2; e.v = re;
        sb.push_back(e);
        if (we && (wa != 5'd0)) mem_m[wa] = wd;
        @(posedge clk);
        #1;
        read_en   = 1'b0;
        reg_write = 1'b0;
    endtask

    task automatic flush();
        #3;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;
        hb1 = 0; hb2 = 0; hn1 = 0; hn2 = 0;
        sb.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        n_checks += 6;
        if (rd1_b !== 32'h0) begin n_errors++; $display("FAIL %s byp_rd1 got %h exp 0", tag, rd1_b); end
        if (rd2_b !== 32'h0) begin n_errors++; $display("FAIL %s byp_rd2 got %h exp 0", tag, rd2_b); end
        if (rd1_n !== 32'h0) begin n_errors++; $display("FAIL %s nob_rd1 got %h exp 0", tag, rd1_n); end
        if (rd2_n !== 32'h0) begin n_errors++; $display("FAIL %s nob_rd2 got %h exp 0", tag, rd2_n); end
        if (vb !== 1'b0) begin n_errors++; $display("FAIL %s byp_valid got %b exp 0", tag, vb); end
        if (vn !== 1'b0) begin n_errors++; $display("FAIL %s nob_valid got %b exp 0", tag, vn); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        read_en = 0; read_reg1 = 0; read_reg2 = 0;
        reg_write = 0; write_reg = 0; write_data = 0;
        model_reset();
        #3;
        check_zero_outputs("reset_initial");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd8, 32'h0000_00FF);
        cyc(1'b1, 5'd8, 5'd0, 1'b0, 5'd0, 32'h0);
        flush();
        n_checks++;
        if (rd1_b !== 32'h0000_00FF) begin
            n_errors++; $display("FAIL write_read_r8 got %h exp 000000ff", rd1_b);
        end
    endtask

    task automatic test_zero_reg();
        cyc(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        cyc(1'b1, 5'd0, 5'd8, 1'b0, 5'd0, 32'h0);
        flush();
    endtask

    task automatic test_bypass();
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'hAAAA_5555);
        cyc(1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 32'h1234_5678);
        cyc(1'b1, 5'd3, 5'd3, 1'b0, 5'd0, 32'h0);
        flush();
    endtask

    task automatic test_hold();
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'hC0DE_0007);
        cyc(1'b1, 5'd7, 5'd8, 1'b0, 5'd0, 32'h0);
        cyc(1'b0, 5'd1, 5'd1, 1'b1, 5'd7, 32'h1111_1111);
        cyc(1'b0, 5'd2, 5'd2, 1'b0, 5'd0, 32'h0);
        cyc(1'b0, 5'bxxxxx, 5'bxxxxx, 1'b0, 5'd0, 32'h0);
        flush();
    endtask

    task automatic test_alu_operands();
        logic [31:0] alu_res;
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd31, 32'h8000_0000);
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd1, 32'h7FFF_FFFF);
        cyc(1'b1, 5'd1, 5'd31, 1'b0, 5'd0, 32'h0);
        flush();
        alu_res = rd1_b - rd2_b;
        n_checks++;
        if (alu_res !== 32'hFFFF_FFFF) begin
            n_errors++; $display("FAIL alu_sub got %h exp ffffffff", alu_res);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  a1, a2, wa;
        logic        we, re;
        logic [31:0] wd;
        for (int i = 0; i < 60; i++) begin
            re = ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 2) != 0);
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            a1 = 5'($urandom_range(0, 31));
            a2 = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) a1 = wa;
            if ($urandom_range(0, 3) == 0) a2 = wa;
            cyc(re, a1, a2, we, wa, wd);
        end
        flush();
    endtask

    task automatic test_reset_mid();
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        cyc(1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0);
        flush();
        rst_n = 1'b0;
        #1;
        check_zero_outputs("reset_mid");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 5'd5, 5'd5, 1'b1, 5'd9, 32'h0000_0909);
        cyc(1'b1, 5'd9, 5'd5, 1'b0, 5'd0, 32'h0);
        flush();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_hold();
        test_alu_operands();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
